ddr2_bit_cal_seq: RTL and testbench

Sequencer for per-bit DQ read calibration of one DQS group.
- Resets all DQ IDELAYs to tap 0, then enables the per-bit tap controller.
- Muxes the selected bit's captured data to the tap controller.
- Demuxes the controller's dlyce/dlyinc to the selected bit's IDELAY.
- Steps through bits 0..DQ_WIDTH-1 and reports group completion to the init/controller logic.

---
 rtl/ddr2_bit_cal_seq_if.sv | 41 ++++
 rtl/ddr2_bit_cal_seq.sv | 195 +++++++++++++++++++
 tb/tb_ddr2_bit_cal_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_bit_cal_seq_if.sv
// ---------------------------------------------------------------------------
// ddr2_bit_cal_seq_if
// Bundles the signals between the per-bit DQ calibration sequencer, the
// init logic, the per-bit tap controller and the group's IDELAYs.
//   master : init logic / tap controller / capture side (drives cal_start,
//            dq_data_in, chan_dlyce, chan_dlyinc, chan_done)
//   slave  : the sequencer (drives dummyread_start, chan_dq, dlyrst, dlyce,
//            dlyinc, bit_sel, cal_busy, cal_done, cal_err)
// Parameters DQ_WIDTH and SEL_W must match those of ddr2_bit_cal_seq.
// ---------------------------------------------------------------------------
interface ddr2_bit_cal_seq_if #(
  parameter int DQ_WIDTH = 8,
  parameter int SEL_W    = 3
);
  logic                cal_start;
  logic [DQ_WIDTH-1:0] dq_data_in;
  logic                chan_dlyce;
  logic                chan_dlyinc;
  logic                chan_done;
  logic                dummyread_start;
  logic                chan_dq;
  logic                dlyrst;
  logic [DQ_WIDTH-1:0] dlyce;
  logic [DQ_WIDTH-1:0] dlyinc;
  logic [SEL_W-1:0]    bit_sel;
  logic                cal_busy;
  logic                cal_done;
  logic                cal_err;

  modport master (
    output cal_start, dq_data_in, chan_dlyce, chan_dlyinc, chan_done,
    input  dummyread_start, chan_dq, dlyrst, dlyce, dlyinc, bit_sel,
           cal_busy, cal_done, cal_err
  );

  modport slave (
    input  cal_start, dq_data_in, chan_dlyce, chan_dlyinc, chan_done,
    output dummyread_start, chan_dq, dlyrst, dlyce, dlyinc, bit_sel,
           cal_busy, cal_done, cal_err
  );
endinterface

// File: rtl/ddr2_bit_cal_seq.sv
// ---------------------------------------------------------------------------
// ddr2_bit_cal_seq
// Per-bit DQ read calibration sequencer for one DQS group. On cal_start it
// pulses the group IDELAY reset, waits RST_SETTLE cycles, then runs the
// per-bit tap controller over bits 0..DQ_WIDTH-1, muxing the selected bit's
// capture data to the controller and steering the controller's CE/INC to
// the selected bit's IDELAY. Reports busy/done (and optionally a timeout).
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : ddr2_bit_cal_seq_if.slave
//     in : cal_start, dq_data_in[DQ_WIDTH], chan_dlyce, chan_dlyinc, chan_done
//     out: dummyread_start, chan_dq, dlyrst, dlyce[DQ_WIDTH],
//          dlyinc[DQ_WIDTH], bit_sel[SEL_W], cal_busy, cal_done, cal_err
//
// Optional build macro DDR2_BIT_CAL_TIMEOUT_EN: adds parameter CAL_TIMEOUT
// and a per-bit watchdog that flags cal_err and forces the bit to advance
// when the tap controller never reports done. Without it cal_err is 0.
// ---------------------------------------------------------------------------
module ddr2_bit_cal_seq #(
  parameter int DQ_WIDTH    = 8,
  parameter int SEL_W       = 3,
  parameter int RST_SETTLE  = 16
`ifdef DDR2_BIT_CAL_TIMEOUT_EN
  ,
  parameter int CAL_TIMEOUT = 4096
`endif
) (
  input logic               clk,
  input logic               reset,
  ddr2_bit_cal_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DLY_RST = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0] LAST_BIT    = SEL_W'(DQ_WIDTH - 1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(RST_SETTLE - 1);

  state_t              state_r;
  logic [SEL_W-1:0]    bit_sel_r;
  logic [7:0]          settle_cnt_r;
  logic                dummyread_start_r;
  logic                dlyrst_r;
  logic                cal_busy_r;
  logic                cal_done_r;
  logic                advance_s;
  logic                chan_dq_s;
  logic [DQ_WIDTH-1:0] dlyce_s;
  logic [DQ_WIDTH-1:0] dlyinc_s;

`ifdef DDR2_BIT_CAL_TIMEOUT_EN
  localparam logic [12:0] WD_LOAD = 13'(CAL_TIMEOUT - 1);

  logic [12:0] wd_r;
  logic        wd_expire_s;
  logic        cal_err_r;

  // An expiry and a real chan_done in the same cycle still advance only once.
  assign wd_expire_s = (state_r == ST_RUN) && (wd_r == 13'd0);
  assign advance_s   = bus.chan_done | wd_expire_s;

  // Per-bit watchdog: reloaded when RUN is entered and whenever a bit advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_r <= 13'd0;
    end else if ((state_r == ST_SETTLE) && (settle_cnt_r == 8'd0)) begin
      wd_r <= WD_LOAD;
    end else if ((state_r == ST_RUN) && advance_s) begin
      wd_r <= WD_LOAD;
    end else if (state_r == ST_RUN) begin
      wd_r <= wd_r - 13'd1;
    end else begin
      wd_r <= wd_r;
    end
  end

  // Sticky timeout flag, cleared only by the start of a new calibration.
  always_ff @(posedge clk) begin
    if (reset) begin
      cal_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.cal_start) begin
      cal_err_r <= 1'b0;
    end else if (wd_expire_s) begin
      cal_err_r <= 1'b1;
    end else begin
      cal_err_r <= cal_err_r;
    end
  end

  assign bus.cal_err = cal_err_r;
`else
  assign advance_s   = bus.chan_done;
  assign bus.cal_err = 1'b0;
`endif

  // Main sequencer FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      bit_sel_r         <= '0;
      settle_cnt_r      <= 8'd0;
      dummyread_start_r <= 1'b0;
      dlyrst_r          <= 1'b0;
      cal_busy_r        <= 1'b0;
      cal_done_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cal_start) begin
            state_r    <= ST_DLY_RST;
            dlyrst_r   <= 1'b1;
            bit_sel_r  <= '0;
            cal_busy_r <= 1'b1;
            cal_done_r <= 1'b0;
          end
        end
        ST_DLY_RST: begin
          // dlyrst was raised on entry, so it is high for exactly this cycle.
          dlyrst_r     <= 1'b0;
          settle_cnt_r <= SETTLE_LOAD;
          state_r      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_r == 8'd0) begin
            state_r           <= ST_RUN;
            dummyread_start_r <= 1'b1;
          end else begin
            settle_cnt_r <= settle_cnt_r - 8'd1;
          end
        end
        ST_RUN: begin
          // The new bit_sel is visible during the controller's pipe-wait
          // cycle, before it samples chan_dq again.
          if (advance_s) begin
            if (bit_sel_r == LAST_BIT) begin
              state_r           <= ST_DONE;
              dummyread_start_r <= 1'b0;
              cal_busy_r        <= 1'b0;
              cal_done_r        <= 1'b1;
            end else begin
              bit_sel_r <= bit_sel_r + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Requires cal_start to drop before another calibration can start.
          if (!bus.cal_start) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r           <= ST_IDLE;
          dummyread_start_r <= 1'b0;
          dlyrst_r          <= 1'b0;
          cal_busy_r        <= 1'b0;
        end
      endcase
    end
  end

  // Capture-data mux and CE/INC demux; zero latency because the controller's
  // CE is a single-cycle combinational pulse.
  always_comb begin
    chan_dq_s = 1'b0;
    dlyce_s   = '0;
    dlyinc_s  = '0;
    for (int i = 0; i < DQ_WIDTH; i++) begin
      if (bit_sel_r == SEL_W'(i)) begin
        chan_dq_s   = bus.dq_data_in[i];
        dlyce_s[i]  = bus.chan_dlyce & (state_r == ST_RUN);
        dlyinc_s[i] = bus.chan_dlyinc & (state_r == ST_RUN);
      end else begin
        dlyce_s[i]  = 1'b0;
        dlyinc_s[i] = 1'b0;
      end
    end
  end

  assign bus.chan_dq         = chan_dq_s;
  assign bus.dlyce           = dlyce_s;
  assign bus.dlyinc          = dlyinc_s;
  assign bus.dummyread_start = dummyread_start_r;
  assign bus.dlyrst          = dlyrst_r;
  assign bus.bit_sel         = bit_sel_r;
  assign bus.cal_busy        = cal_busy_r;
  assign bus.cal_done        = cal_done_r;

endmodule

// File: tb/tb_ddr2_bit_cal_seq.sv
// ---------------------------------------------------------------------------
// tb_ddr2_bit_cal_seq
// Scoreboard bench: the stimulus process predicts every change of the
// registered outputs (with the cycle it must appear in) and queues it; the
// monitor pops entries when the DUT outputs change or an entry falls due,
// and checks the combinational mux/demux every cycle against the expected
// RUN/bit_sel state.
// ---------------------------------------------------------------------------
module tb_ddr2_bit_cal_seq;
  localparam int DQ_WIDTH   = 8;
  localparam int SEL_W      = 3;
  localparam int RST_SETTLE = 16;
`ifdef DDR2_BIT_CAL_TIMEOUT_EN
  localparam int CAL_TIMEOUT = 100;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  ddr2_bit_cal_seq_if #(.DQ_WIDTH(DQ_WIDTH), .SEL_W(SEL_W)) bus ();

`ifdef DDR2_BIT_CAL_TIMEOUT_EN
  ddr2_bit_cal_seq #(.DQ_WIDTH(DQ_WIDTH), .SEL_W(SEL_W), .RST_SETTLE(RST_SETTLE),
                     .CAL_TIMEOUT(CAL_TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  ddr2_bit_cal_seq #(.DQ_WIDTH(DQ_WIDTH), .SEL_W(SEL_W), .RST_SETTLE(RST_SETTLE)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic             dlyrst;
    logic             drs;
    logic [SEL_W-1:0] bsel;
    logic             busy;
    logic             done;
    logic             err;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t  exp_q[$];
  snap_t m;
  snap_t exp_cur = '0;
  snap_t prev_dut = '0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;

  // Cycle index: cycle k is the period following the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t dut_snap();
    return {bus.dlyrst, bus.dummyread_start, bus.bit_sel, bus.cal_busy,
            bus.cal_done, bus.cal_err};
  endfunction

  task automatic push(input int at);
    exp_t e;
    e.cyc = at;
    e.s   = m;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Background random data and tap-controller CE/INC activity.
  initial begin
    bus.dq_data_in  = '0;
    bus.chan_dlyce  = 1'b0;
    bus.chan_dlyinc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.dq_data_in  = DQ_WIDTH'($urandom);
      bus.chan_dlyce  = 1'($urandom_range(0, 1));
      bus.chan_dlyinc = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pops plus per-cycle mux/demux check.
  always @(negedge clk) begin
    snap_t               cur;
    exp_t                e;
    logic [DQ_WIDTH-1:0] e_ce;
    logic [DQ_WIDTH-1:0] e_inc;
    logic [DQ_WIDTH-1:0] dq_tmp;
    logic                e_dq;
    bit                  popped;
    if (mon_en) begin
      cur    = dut_snap();
      popped = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        exp_cur = e.s;
        n_checks++;
        n_fail++;
        $display("FAIL missed_event cyc=%0d due=%0d actual=%h required=%h", cyc, e.cyc, cur, e.s);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        exp_cur = e.s;
        popped = 1'b1;
      end
      if (popped || (cur !== prev_dut)) begin
        n_checks++;
        if (cur !== exp_cur) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d actual(dlyrst,drs,bit,busy,done,err)=%b_%b_%0d_%b_%b_%b required=%b_%b_%0d_%b_%b_%b",
                   cyc, cur.dlyrst, cur.drs, cur.bsel, cur.busy, cur.done, cur.err,
                   exp_cur.dlyrst, exp_cur.drs, exp_cur.bsel, exp_cur.busy, exp_cur.done, exp_cur.err);
        end
      end
      prev_dut = cur;
      e_ce  = '0;
      e_inc = '0;
      // dummyread_start is high exactly while the sequencer is in RUN.
      if (exp_cur.drs) begin
        e_ce[exp_cur.bsel]  = bus.chan_dlyce;
        e_inc[exp_cur.bsel] = bus.chan_dlyinc;
      end
      dq_tmp = bus.dq_data_in;
      e_dq   = dq_tmp[exp_cur.bsel];
      n_checks++;
      if ({bus.dlyce, bus.dlyinc, bus.chan_dq} !== {e_ce, e_inc, e_dq}) begin
        n_fail++;
        $display("FAIL demux cyc=%0d actual ce=%h inc=%h dq=%b required ce=%h inc=%h dq=%b",
                 cyc, bus.dlyce, bus.dlyinc, bus.chan_dq, e_ce, e_inc, e_dq);
      end
    end
  end

  // Start a calibration; a stray chan_done is injected during SETTLE.
  task automatic start_cal(input bit level);
    int k;
    k = cyc;
    bus.cal_start = 1'b1;
    m.dlyrst = 1'b1;
    m.busy   = 1'b1;
    m.done   = 1'b0;
    m.err    = 1'b0;
    m.bsel   = '0;
    push(k + 1);
    m.dlyrst = 1'b0;
    push(k + 2);
    m.drs = 1'b1;
    push(k + RST_SETTLE + 2);
    tick();
    if (!level) bus.cal_start = 1'b0;
    tick();
    tick();
    bus.chan_done = 1'b1;
    tick();
    bus.chan_done = 1'b0;
    while (cyc < k + RST_SETTLE + 2) tick();
  endtask

  // Advance n bits; fixed_gap>0 spaces chan_done pulses exactly that far apart.
  task automatic do_bits(input int n, input int fixed_gap, input bit poke, input bit level);
    int gap;
    int j;
    for (int i = 0; i < n; i++) begin
      gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(2, 20));
      for (int t = 0; t < gap - 1; t++) begin
        bus.cal_start = (poke && i == 3 && t == 0) ? 1'b1 : level;
        tick();
      end
      bus.cal_start = level;
      bus.chan_done = 1'b1;
      j = cyc;
      if (m.bsel < SEL_W'(DQ_WIDTH - 1)) begin
        m.bsel = m.bsel + SEL_W'(1);
      end else begin
        m.drs  = 1'b0;
        m.busy = 1'b0;
        m.done = 1'b1;
      end
      push(j + 1);
      tick();
      bus.chan_done = 1'b0;
    end
  endtask

`ifdef DDR2_BIT_CAL_TIMEOUT_EN
  // Withhold chan_done for the current bit until the watchdog forces it on.
  task automatic stall_bit();
    int e;
    e = cyc;
    m.err  = 1'b1;
    m.bsel = m.bsel + SEL_W'(1);
    push(e + CAL_TIMEOUT);
    repeat (CAL_TIMEOUT) tick();
  endtask
`endif

  initial begin
    int r;
    bus.cal_start = 1'b0;
    bus.chan_done = 1'b0;
    m = '0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ((dut_snap() !== 8'h00) || (bus.dlyce !== '0) || (bus.dlyinc !== '0)) begin
      n_fail++;
      $display("FAIL reset_state actual=%h ce=%h inc=%h required=00 ce=00 inc=00",
               dut_snap(), bus.dlyce, bus.dlyinc);
    end
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Run 1: pulsed start, chan_done every 50 cycles.
    start_cal(1'b0);
    do_bits(DQ_WIDTH, 50, 1'b0, 1'b0);
    repeat (5) tick();

    // Run 2: level start held through DONE; stray chan_done in DONE.
    start_cal(1'b1);
    do_bits(DQ_WIDTH, 0, 1'b0, 1'b1);
    repeat (2) tick();
    bus.chan_done = 1'b1;
    tick();
    bus.chan_done = 1'b0;
    repeat (3) tick();
    bus.cal_start = 1'b0;
    repeat (3) tick();

    // Run 3: start poked while busy, then reset at bit 5.
    start_cal(1'b0);
    do_bits(5, 0, 1'b1, 1'b0);
    repeat (3) tick();
    r = cyc;
    reset = 1'b1;
    m = '0;
    push(r + 1);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Run 4: fresh start after reset.
    start_cal(1'b0);
`ifdef DDR2_BIT_CAL_TIMEOUT_EN
    do_bits(2, 0, 1'b0, 1'b0);
    stall_bit();
    do_bits(DQ_WIDTH - 3, 0, 1'b0, 1'b0);
`else
    do_bits(DQ_WIDTH, 0, 1'b0, 1'b0);
`endif
    repeat (5) tick();

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
